// File: rtl/fsm_sequencer_mc.sv
// Multi-cycle FETCH/DECODE/EXEC/WB sequencer for MINI_CPU. It owns the program
// counter and the retired-instruction counter, and drives the one-hot stage enables.
module fsm_sequencer_mc #(
  parameter int unsigned PC_W        = 8,
  parameter int unsigned PC_STEP     = 1,
  parameter int unsigned RESET_PC    = 0,
  parameter int unsigned EXEC_CYCLES = 1,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mem_ready,
  input  logic             branch_taken,
  input  logic [PC_W-1:0]  branch_target,
  input  logic             halt_req,
  input  logic             resume,
  output logic [PC_W-1:0]  pc,
  output logic             fetch_en,
  output logic             decode_en,
  output logic             exec_en,
  output logic             wb_en,
  output logic [2:0]       state,
  output logic             halted,
  output logic [CNT_W-1:0] retired
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_WB     = 3'd3;
  localparam logic [2:0] S_HALT   = 3'd4;

  localparam logic [3:0] EXEC_LAST = 4'(EXEC_CYCLES - 1);

  logic [2:0]       state_q;
  logic [PC_W-1:0]  pc_q;
  logic [PC_W-1:0]  tgt_q;
  logic [CNT_W-1:0] retired_q;
  logic [3:0]       exec_cnt;
  logic             br_q;
  logic             halt_pend;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_FETCH;
      pc_q      <= PC_W'(RESET_PC);
      tgt_q     <= '0;
      retired_q <= '0;
      exec_cnt  <= '0;
      br_q      <= 1'b0;
      halt_pend <= 1'b0;
    end else begin
      // A request is remembered in every non-HALT state; the clear below for
      // HALT entry is placed after it so the clear takes priority.
      if (state_q != S_HALT && halt_req)
        halt_pend <= 1'b1;

      case (state_q)
        S_FETCH: begin
          if (mem_ready)
            state_q <= S_DECODE;
        end
        S_DECODE: begin
          exec_cnt <= '0;
          state_q  <= S_EXEC;
        end
        S_EXEC: begin
          if (exec_cnt == EXEC_LAST) begin
            br_q     <= branch_taken;
            tgt_q    <= branch_target;
            exec_cnt <= '0;
            state_q  <= S_WB;
          end else begin
            exec_cnt <= exec_cnt + 4'd1;
          end
        end
        S_WB: begin
          retired_q <= retired_q + CNT_W'(1);
          pc_q      <= br_q ? tgt_q : pc_q + PC_W'(PC_STEP);
          if (halt_pend || halt_req) begin
            state_q   <= S_HALT;
            halt_pend <= 1'b0;
          end else begin
            state_q <= S_FETCH;
          end
        end
        S_HALT: begin
          if (resume)
            state_q <= S_FETCH;
        end
        default: state_q <= S_FETCH;
      endcase
    end
  end

  always_comb begin
    state     = state_q;
    pc        = pc_q;
    retired   = retired_q;
    fetch_en  = (state_q == S_FETCH);
    decode_en = (state_q == S_DECODE);
    exec_en   = (state_q == S_EXEC);
    wb_en     = (state_q == S_WB);
    halted    = (state_q == S_HALT);
  end

endmodule

// File: tb/tb_fsm_sequencer_mc.sv
// Bench for fsm_sequencer_mc: directed scenarios plus random traffic, all compared
// against an instruction-level reference model.
module tb_fsm_sequencer_mc;

  localparam int unsigned E = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       mem_ready = 1'b0;
  logic       branch_taken = 1'b0;
  logic [7:0] branch_target = '0;
  logic       halt_req = 1'b0;
  logic       resume = 1'b0;
  logic [7:0] pc;
  logic       fetch_en, decode_en, exec_en, wb_en, halted;
  logic [2:0] state;
  logic [15:0] retired;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: where the current instruction stands.
  bit          m_fetching, m_halted, m_br, m_pend;
  int          m_k;          // cycles since DECODE began: 0 decode, 1..E exec, E+1 wb
  logic [7:0]  m_pc, m_tgt;
  logic [15:0] m_ret;

  fsm_sequencer_mc #(
    .PC_W(8), .PC_STEP(1), .RESET_PC(0), .EXEC_CYCLES(E), .CNT_W(16)
  ) dut (
    .clk(clk), .reset(reset), .mem_ready(mem_ready), .branch_taken(branch_taken),
    .branch_target(branch_target), .halt_req(halt_req), .resume(resume),
    .pc(pc), .fetch_en(fetch_en), .decode_en(decode_en), .exec_en(exec_en),
    .wb_en(wb_en), .state(state), .halted(halted), .retired(retired)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_fetching = 1; m_halted = 0; m_br = 0; m_pend = 0;
    m_k = 0; m_pc = 8'h00; m_tgt = 8'h00; m_ret = 16'h0;
  endtask

  function automatic int exp_state();
    if (m_halted) return 4;
    if (m_fetching) return 0;
    if (m_k == 0) return 1;
    if (m_k <= E) return 2;
    return 3;
  endfunction

  task automatic check_all();
    int s;
    logic [4:0] en;
    s = exp_state();
    en = {s == 0, s == 1, s == 2, s == 3, s == 4};
    chk("state", 32'(state), 32'(s));
    chk("enables", 32'({fetch_en, decode_en, exec_en, wb_en, halted}), 32'(en));
    chk("pc", 32'(pc), 32'(m_pc));
    chk("retired", 32'(retired), 32'(m_ret));
  endtask

  task automatic model_step(input bit mr, bt, input logic [7:0] tg, input bit hr, rs);
    bit pend_n;
    if (m_halted) begin
      if (rs) begin m_halted = 0; m_fetching = 1; end
      return;
    end
    pend_n = m_pend | hr;
    if (m_fetching) begin
      if (mr) begin m_fetching = 0; m_k = 0; end
    end else if (m_k == E + 1) begin
      m_ret = m_ret + 16'd1;
      m_pc  = m_br ? m_tgt : m_pc + 8'd1;
      if (pend_n) begin m_halted = 1; pend_n = 0; end
      else m_fetching = 1;
    end else begin
      if (m_k == E) begin m_br = bt; m_tgt = tg; end
      m_k++;
    end
    m_pend = pend_n;
  endtask

  // Called at a point away from the rising edge; returns at the next negedge.
  task automatic cyc(input bit mr, bt, input logic [7:0] tg, input bit hr, rs);
    check_all();
    mem_ready = mr; branch_taken = bt; branch_target = tg; halt_req = hr; resume = rs;
    @(posedge clk);
    model_step(mr, bt, tg, hr, rs);
    @(negedge clk);
  endtask

  // One instruction from FETCH with memory ready: branch inputs per EXEC cycle,
  // optional halt request during DECODE.
  task automatic run_instr(input bit bt1, bt2, input logic [7:0] tg, input bit hr_dec);
    cyc(1, 0, 8'h00, 0, 0);
    cyc(0, 0, 8'h00, hr_dec, 0);
    cyc(0, bt1, tg, 0, 0);
    cyc(0, bt2, tg, 0, 0);
    cyc(0, 0, 8'h00, 0, 0);
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_pc", 32'(pc), 32'd0);
    chk("rst_retired", 32'(retired), 32'd0);
    chk("rst_enables", 32'({fetch_en, decode_en, exec_en, wb_en, halted}), 32'b10000);
    reset = 1'b0;

    // Back-to-back instructions with memory always ready.
    repeat (15) cyc(1, 0, 8'h00, 0, 0);
    chk("seq_pc3", 32'(pc), 32'd3);
    chk("seq_ret3", 32'(retired), 32'd3);

    // Fetch wait-states.
    repeat (3) cyc(0, 0, 8'h00, 0, 0);
    chk("wait_fetch", 32'(fetch_en), 32'd1);
    run_instr(0, 0, 8'h00, 0);

    // Branch on final EXEC cycle is taken, on first EXEC cycle is ignored.
    run_instr(0, 1, 8'h40, 0);
    chk("branch_pc", 32'(pc), 32'h40);
    run_instr(1, 0, 8'h80, 0);
    chk("early_branch_pc", 32'(pc), 32'h41);

    // PC wrap.
    run_instr(0, 1, 8'hFF, 0);
    chk("pre_wrap_pc", 32'(pc), 32'hFF);
    run_instr(0, 0, 8'h00, 0);
    chk("wrap_pc", 32'(pc), 32'h00);

    // Halt requested during DECODE; halt_req ignored while halted; resume.
    run_instr(0, 0, 8'h00, 1);
    chk("halted", 32'(halted), 32'd1);
    repeat (3) cyc(1, 0, 8'h00, 1, 0);
    chk("halt_pc_frozen", 32'(pc), 32'h01);
    cyc(1, 0, 8'h00, 1, 1);
    chk("resume_fetch", 32'(fetch_en), 32'd1);
    chk("resume_pc", 32'(pc), 32'h01);

    // Asynchronous reset mid-EXEC.
    cyc(1, 0, 8'h00, 0, 0);
    cyc(0, 0, 8'h00, 0, 0);
    chk("pre_rst_exec", 32'(exec_en), 32'd1);
    #1 reset = 1'b1;
    #1;
    chk("arst_state", 32'(state), 32'd0);
    chk("arst_pc", 32'(pc), 32'd0);
    chk("arst_retired", 32'(retired), 32'd0);
    chk("arst_fetch", 32'(fetch_en), 32'd1);
    reset = 1'b0;
    model_reset();
    repeat (10) cyc(1, 0, 8'h00, 0, 0);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      cyc($urandom_range(3, 0) != 0, $urandom_range(3, 0) == 0, 8'($urandom),
          $urandom_range(19, 0) == 0, $urandom_range(2, 0) == 0);
    end
    check_all();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
